// File: rtl/boot_loader_ctrl.sv
// ---------------------------------------------------------------------------
// boot_loader_ctrl
//   Power-up program loader. Receives a length-prefixed byte stream from the
//   host link and writes the payload into RAM through the MMU boot path. The
//   CPU is held in reset until the whole image is in RAM and its 8-bit
//   checksum matches.
//
//   Stream format: LEN_LO, LEN_HI, LEN payload bytes, CSUM.
//   CSUM is the mod-256 sum of the payload bytes.
//
// Ports
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   rx_data    byte from host link
//   rx_valid   rx_data valid
//   rx_ready   controller accepts rx_data (transfer = rx_valid & rx_ready)
//   boot_skip  in LEN_LO: bypass the load and go straight to DONE
//   reboot     single-cycle pulse, restarts the load from DONE/ERROR
//   booting    MMU selects boot_data as the RAM write source
//   boot_addr  RAM write address
//   boot_data  RAM write data
//   ram_we     one-cycle RAM write strobe
//   cpu_rst_n  active-low CPU reset
//   boot_done  image loaded and checksum passed
//   boot_err   length or checksum error, sticky until reboot/reset
// ---------------------------------------------------------------------------
module boot_loader_ctrl #(
    parameter logic [15:0] LOAD_BASE   = 16'h0100,
    parameter logic [15:0] MAX_LEN     = 16'h0F00,
    parameter int unsigned RELEASE_DLY = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic        boot_skip,
    input  logic        reboot,
    output logic        booting,
    output logic [15:0] boot_addr,
    output logic [7:0]  boot_data,
    output logic        ram_we,
    output logic        cpu_rst_n,
    output logic        boot_done,
    output logic        boot_err
);

    typedef enum logic [2:0] {
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [3:0] DLY_LAST = 4'(RELEASE_DLY - 1);

    state_t      r_state;
    logic [15:0] r_len;
    logic [15:0] r_cnt;
    logic [7:0]  r_sum;
    logic [3:0]  r_dly;

    logic        r_rx_ready;
    logic        r_booting;
    logic [15:0] r_boot_addr;
    logic [7:0]  r_boot_data;
    logic        r_ram_we;
    logic        r_cpu_rst_n;
    logic        r_boot_done;
    logic        r_boot_err;

    logic        w_xfer;
    logic [15:0] w_len_full;

    assign w_xfer     = rx_valid & r_rx_ready;
    assign w_len_full = {rx_data, r_len[7:0]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_LEN_LO;
            r_len       <= '0;
            r_cnt       <= '0;
            r_sum       <= '0;
            r_dly       <= '0;
            r_rx_ready  <= 1'b0;
            r_booting   <= 1'b1;
            r_boot_addr <= LOAD_BASE;
            r_boot_data <= '0;
            r_ram_we    <= 1'b0;
            r_cpu_rst_n <= 1'b0;
            r_boot_done <= 1'b0;
            r_boot_err  <= 1'b0;
        end else begin
            // Strobe lasts one cycle; the address advances the cycle after
            // each strobe so back-to-back bytes land at consecutive addresses.
            r_ram_we <= 1'b0;
            if (r_ram_we) begin
                r_boot_addr <= r_boot_addr + 16'd1;
            end

            case (r_state)
                S_LEN_LO: begin
                    if (boot_skip) begin
                        r_state     <= S_DONE;
                        r_rx_ready  <= 1'b0;
                        r_booting   <= 1'b0;
                        r_boot_done <= 1'b1;
                        r_dly       <= '0;
                    end else begin
                        // Ready comes up one cycle after reset/reboot.
                        r_rx_ready <= 1'b1;
                        if (w_xfer) begin
                            r_len[7:0] <= rx_data;
                            r_state    <= S_LEN_HI;
                        end
                    end
                end

                S_LEN_HI: begin
                    if (w_xfer) begin
                        r_len[15:8] <= rx_data;
                        r_sum       <= '0;
                        r_cnt       <= '0;
                        r_boot_addr <= LOAD_BASE;
                        if (w_len_full == 16'd0) begin
                            r_state <= S_CSUM;
                        end else if (w_len_full > MAX_LEN) begin
                            r_state    <= S_ERROR;
                            r_rx_ready <= 1'b0;
                            r_boot_err <= 1'b1;
                        end else begin
                            r_state <= S_DATA;
                        end
                    end
                end

                S_DATA: begin
                    if (w_xfer) begin
                        r_boot_data <= rx_data;
                        r_sum       <= r_sum + rx_data;
                        r_ram_we    <= 1'b1;
                        r_cnt       <= r_cnt + 16'd1;
                        if (r_cnt == r_len - 16'd1) begin
                            r_state <= S_CSUM;
                        end
                    end
                end

                S_CSUM: begin
                    if (w_xfer) begin
                        r_rx_ready <= 1'b0;
                        if (rx_data == r_sum) begin
                            r_state     <= S_DONE;
                            r_booting   <= 1'b0;
                            r_boot_done <= 1'b1;
                            r_dly       <= '0;
                        end else begin
                            r_state    <= S_ERROR;
                            r_boot_err <= 1'b1;
                        end
                    end
                end

                S_DONE: begin
                    if (reboot) begin
                        r_state     <= S_LEN_LO;
                        r_rx_ready  <= 1'b1;
                        r_booting   <= 1'b1;
                        r_cpu_rst_n <= 1'b0;
                        r_boot_done <= 1'b0;
                        r_boot_addr <= LOAD_BASE;
                    end else if (!r_cpu_rst_n) begin
                        // Counts DONE cycles; release lands on the
                        // RELEASE_DLY-th edge after entering DONE.
                        if (r_dly == DLY_LAST) begin
                            r_cpu_rst_n <= 1'b1;
                        end else begin
                            r_dly <= r_dly + 4'd1;
                        end
                    end
                end

                S_ERROR: begin
                    if (reboot) begin
                        r_state     <= S_LEN_LO;
                        r_rx_ready  <= 1'b1;
                        r_boot_err  <= 1'b0;
                        r_boot_addr <= LOAD_BASE;
                    end
                end

                default: begin
                    r_state <= S_LEN_LO;
                end
            endcase
        end
    end

    assign rx_ready  = r_rx_ready;
    assign booting   = r_booting;
    assign boot_addr = r_boot_addr;
    assign boot_data = r_boot_data;
    assign ram_we    = r_ram_we;
    assign cpu_rst_n = r_cpu_rst_n;
    assign boot_done = r_boot_done;
    assign boot_err  = r_boot_err;

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// ---------------------------------------------------------------------------
// tb_boot_loader_ctrl
//   Table of boot streams applied in a loop; every RAM write is matched
//   against a queue of expected {addr,data} pairs pushed as payload bytes
//   are driven. Hand-written sequences cover reset, async abort mid-DATA,
//   the MAX_LEN boundary and boot_skip.
// ---------------------------------------------------------------------------
module tb_boot_loader_ctrl;

    localparam logic [15:0] LOAD_BASE   = 16'h0100;
    localparam logic [15:0] MAX_LEN     = 16'h0F00;
    localparam int          RELEASE_DLY = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        boot_skip;
    logic        reboot;
    logic        booting;
    logic [15:0] boot_addr;
    logic [7:0]  boot_data;
    logic        ram_we;
    logic        cpu_rst_n;
    logic        boot_done;
    logic        boot_err;

    boot_loader_ctrl #(
        .LOAD_BASE  (LOAD_BASE),
        .MAX_LEN    (MAX_LEN),
        .RELEASE_DLY(RELEASE_DLY)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .boot_skip (boot_skip),
        .reboot    (reboot),
        .booting   (booting),
        .boot_addr (boot_addr),
        .boot_data (boot_data),
        .ram_we    (ram_we),
        .cpu_rst_n (cpu_rst_n),
        .boot_done (boot_done),
        .boot_err  (boot_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0][7:0] bytes;
        int              nbytes;
        int              gap;
        bit              exp_done;
        bit              exp_err;
        int              exp_writes;
    } vec_t;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t  exp_q[$];
    vec_t tbl[7];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   wr_cnt   = 0;

    function automatic vec_t mk(input int n, input logic [7:0] b0, input logic [7:0] b1,
                                input logic [7:0] b2, input logic [7:0] b3,
                                input logic [7:0] b4, input logic [7:0] b5,
                                input int gap, input bit d, input bit e, input int w);
        vec_t v;
        v.bytes      = {b5, b4, b3, b2, b1, b0};
        v.nbytes     = n;
        v.gap        = gap;
        v.exp_done   = d;
        v.exp_err    = e;
        v.exp_writes = w;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // One clock of progress; outputs sampled on the falling edge, where
    // every RAM strobe is checked against the expected-write queue.
    task automatic tick();
        wr_t e;
        @(negedge clk);
        if (ram_we === 1'b1) begin
            wr_cnt++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got %04h/%02h, required no write",
                         boot_addr, boot_data);
            end else begin
                e = exp_q.pop_front();
                if (boot_addr !== e.addr || boot_data !== e.data) begin
                    n_fail++;
                    $display("FAIL write: got %04h/%02h, required %04h/%02h",
                             boot_addr, boot_data, e.addr, e.data);
                end else begin
                    $display("write %04h/%02h", boot_addr, boot_data);
                end
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int w = 0;
        while (rx_ready !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        chk("rx_ready_before_byte", 32'(rx_ready), 32'd1);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic wait_end();
        int k = 0;
        while (!(boot_done === 1'b1 || boot_err === 1'b1) && k < 20) begin
            tick();
            k++;
        end
    endtask

    // Called on the first DONE cycle: counts cycles until the CPU is released.
    task automatic chk_release(input string name);
        int k = 0;
        while (cpu_rst_n !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        chk(name, 32'(k), 32'(RELEASE_DLY));
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_rx_ready"},  32'(rx_ready),  32'd0);
        chk({tag, "_booting"},   32'(booting),   32'd1);
        chk({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'd0);
        chk({tag, "_ram_we"},    32'(ram_we),    32'd0);
        chk({tag, "_boot_addr"}, 32'(boot_addr), 32'(LOAD_BASE));
        chk({tag, "_boot_data"}, 32'(boot_data), 32'd0);
        chk({tag, "_boot_done"}, 32'(boot_done), 32'd0);
        chk({tag, "_boot_err"},  32'(boot_err),  32'd0);
    endtask

    task automatic do_reboot();
        reboot = 1'b1;
        tick();
        reboot = 1'b0;
        chk("reboot_booting",   32'(booting),   32'd1);
        chk("reboot_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        chk("reboot_boot_done", 32'(boot_done), 32'd0);
        chk("reboot_boot_err",  32'(boot_err),  32'd0);
        chk("reboot_rx_ready",  32'(rx_ready),  32'd1);
    endtask

    task automatic run_case(input vec_t v, input int idx);
        logic [15:0] len;
        int          base;
        len  = {v.bytes[1], v.bytes[0]};
        base = wr_cnt;
        for (int i = 0; i < v.nbytes; i++) begin
            if (i > 0) begin
                repeat ($urandom_range(v.gap)) tick();
            end
            if (i >= 2 && len <= MAX_LEN && (i - 2) < int'(len)) begin
                exp_q.push_back(wr_t'{addr: LOAD_BASE + 16'(i - 2), data: v.bytes[i]});
            end
            send_byte(v.bytes[i]);
        end
        wait_end();
        chk("boot_done", 32'(boot_done), 32'(v.exp_done));
        chk("boot_err",  32'(boot_err),  32'(v.exp_err));
        chk("booting",   32'(booting),   32'(!v.exp_done));
        chk("cpu_rst_n_held", 32'(cpu_rst_n), 32'd0);
        chk("rx_ready_idle",  32'(rx_ready),  32'd0);
        if (v.exp_done) begin
            chk_release("release_delay");
        end else begin
            repeat (RELEASE_DLY + 2) tick();
            chk("err_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
            chk("err_sticky",    32'(boot_err),  32'd1);
        end
        chk("write_count", 32'(wr_cnt - base), 32'(v.exp_writes));
        $display("case %0d: len=%04h done=%0b err=%0b writes=%0d",
                 idx, len, boot_done, boot_err, wr_cnt - base);
        exp_q.delete();
    endtask

    initial begin
        int base;
        rx_data   = 8'h00;
        rx_valid  = 1'b0;
        boot_skip = 1'b0;
        reboot    = 1'b0;
        reset_n   = 1'b0;

        tbl[0] = mk(6, 8'h03, 8'h00, 8'hAA, 8'h55, 8'h01, 8'h00, 0, 1'b1, 1'b0, 3);
        tbl[1] = mk(5, 8'h02, 8'h00, 8'h10, 8'h20, 8'h31, 8'h00, 0, 1'b0, 1'b1, 2);
        tbl[2] = mk(3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1'b1, 1'b0, 0);
        tbl[3] = mk(3, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 0, 1'b0, 1'b1, 0);
        tbl[4] = mk(2, 8'h01, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1'b0, 1'b1, 0);
        tbl[5] = mk(6, 8'h03, 8'h00, 8'hAA, 8'h55, 8'h01, 8'h00, 3, 1'b1, 1'b0, 3);
        tbl[6] = mk(4, 8'h01, 8'h00, 8'h7E, 8'h7E, 8'h00, 8'h00, 0, 1'b1, 1'b0, 1);

        tick();
        tick();
        chk_reset("reset");
        reset_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            if (i > 0) begin
                do_reboot();
            end
            run_case(tbl[i], i);
        end

        // Largest legal length is accepted, then the load is aborted
        // asynchronously while a write strobe is active.
        do_reboot();
        send_byte(8'h00);
        send_byte(8'h0F);
        chk("maxlen_no_err", 32'(boot_err), 32'd0);
        exp_q.push_back(wr_t'{addr: LOAD_BASE,         data: 8'hC3});
        send_byte(8'hC3);
        exp_q.push_back(wr_t'{addr: LOAD_BASE + 16'd1, data: 8'h3C});
        send_byte(8'h3C);
        chk("mid_data_we", 32'(ram_we), 32'd1);
        chk("mid_data_queue_empty", 32'(exp_q.size()), 32'd0);
        reset_n = 1'b0;
        #1;
        chk_reset("async");
        $display("async reset mid-DATA applied");
        exp_q.delete();
        tick();

        // boot_skip straight out of reset.
        boot_skip = 1'b1;
        base      = wr_cnt;
        #1;
        reset_n = 1'b1;
        wait_end();
        boot_skip = 1'b0;
        chk("skip_done",    32'(boot_done), 32'd1);
        chk("skip_err",     32'(boot_err),  32'd0);
        chk("skip_booting", 32'(booting),   32'd0);
        chk_release("skip_release_delay");
        chk("skip_writes", 32'(wr_cnt - base), 32'd0);
        $display("boot_skip: done=%0b cpu_rst_n=%0b", boot_done, cpu_rst_n);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
